// File: rtl/aq_axi_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 memory responder.
package aq_axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/aq_axi_mem_dpram.sv
// Simple dual-port RAM: one byte-enabled write port, one synchronous read-first read port.
module aq_axi_mem_dpram #(
  parameter int MEM_AW = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [7:0]        i_wbe,
  input  logic [MEM_AW-1:0] i_waddr,
  input  logic [63:0]       i_wdata,
  input  logic              i_re,
  input  logic [MEM_AW-1:0] i_raddr,
  output logic [63:0]       o_rdata
);

  logic [63:0] r_mem [0:(1<<MEM_AW)-1];

  // Read sees the pre-write contents when both ports hit the same word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/aq_axi_mem_slave64.sv
// AXI4 64-bit memory responder: independent write and read burst FSMs around a dual-port RAM.
module aq_axi_mem_slave64
  import aq_axi_mem_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [LEN_W-1:0]  S_AXI_AWLEN,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [63:0]       S_AXI_WDATA,
  input  logic [7:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [LEN_W-1:0]  S_AXI_ARLEN,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [63:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  localparam logic [MEM_AW-1:0] ONE_IDX = MEM_AW'(1);
  localparam logic [LEN_W-1:0]  ONE_LEN = LEN_W'(1);

  w_state_t          r_wstate;
  logic              r_awready;
  logic [MEM_AW-1:0] r_windex;
  logic [LEN_W-1:0]  r_wlen;
  logic [LEN_W-1:0]  r_wcount;
  logic              r_werr;

  r_state_t          r_rstate;
  logic              r_arready;
  logic [MEM_AW-1:0] r_rindex;
  logic [LEN_W-1:0]  r_rlen;
  logic [LEN_W-1:0]  r_rcount;

  logic              w_wready;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wlast_beat;
  logic              w_rvalid;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_rlast_beat;
  logic              w_ram_re;
  logic [MEM_AW-1:0] w_ram_raddr;
  logic [63:0]       w_ram_rdata;
  logic              w_unused_addr;

  // Address bits outside the word index are deliberately ignored.
  assign w_unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign w_wready     = (r_wstate == W_DATA);
  assign w_aw_hs      = S_AXI_AWVALID & r_awready;
  assign w_w_hs       = S_AXI_WVALID & w_wready;
  assign w_wlast_beat = (r_wcount == r_wlen);

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = (S_AXI_BVALID && r_werr) ? RESP_SLVERR : RESP_OKAY;

  // The burst always runs for AWLEN+1 beats; a misplaced WLAST only flags SLVERR.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_windex  <= '0;
      r_wlen    <= '0;
      r_wcount  <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_windex  <= S_AXI_AWADDR[3 +: MEM_AW];
            r_wlen    <= S_AXI_AWLEN;
            r_wcount  <= '0;
            r_werr    <= 1'b0;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_windex <= r_windex + ONE_IDX;
            r_wcount <= r_wcount + ONE_LEN;
            if (S_AXI_WLAST != w_wlast_beat) r_werr <= 1'b1;
            if (w_wlast_beat) r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_rvalid     = (r_rstate == R_DATA);
  assign w_ar_hs      = S_AXI_ARVALID & r_arready;
  assign w_r_hs       = w_rvalid & S_AXI_RREADY;
  assign w_rlast_beat = (r_rcount == r_rlen);

  // Prefetch the next word on each accepted beat so data streams one beat per cycle.
  assign w_ram_re    = w_ar_hs | (w_r_hs & ~w_rlast_beat);
  assign w_ram_raddr = (r_rstate == R_IDLE) ? S_AXI_ARADDR[3 +: MEM_AW] : r_rindex + ONE_IDX;

  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RLAST   = w_rvalid & w_rlast_beat;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = w_rvalid ? w_ram_rdata : 64'd0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rindex  <= '0;
      r_rlen    <= '0;
      r_rcount  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rindex  <= S_AXI_ARADDR[3 +: MEM_AW];
            r_rlen    <= S_AXI_ARLEN;
            r_rcount  <= '0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (w_rlast_beat) begin
              r_rstate  <= R_IDLE;
              r_arready <= 1'b1;
            end else begin
              r_rindex <= r_rindex + ONE_IDX;
              r_rcount <= r_rcount + ONE_LEN;
            end
          end
        end
      endcase
    end
  end

  aq_axi_mem_dpram #(
    .MEM_AW (MEM_AW)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_w_hs),
    .i_wbe   (S_AXI_WSTRB),
    .i_waddr (r_windex),
    .i_wdata (S_AXI_WDATA),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

endmodule
